icache_controller: RTL and testbench

- Sequencing FSM for a direct-mapped read-only instruction cache built from one cache-set datapath (synchronous data + metadata memories, 1-cycle read latency, combinational hit).
- Accepts CPU fetch requests and checks hits. On a miss it fetches the word from backing memory over a req/ack handshake, then writes it into the set.
- Invalidates every index after reset and on a flush request.

---
 rtl/icache_controller_if.sv | 49 ++++
 rtl/icache_controller.sv | 160 ++++++++++++++++
 tb/tb_icache_controller.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_controller_if.sv
// Bundles the CPU fetch port, backing-memory port and cache-set datapath port of the icache controller.
// Latency: none, wiring only.
// Backpressure: carried by o_ready (CPU side) and o_mem_rd/i_mem_ack (memory side).
interface icache_controller_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int INDEX_WIDTH  = 6,
    parameter int OFFSET_WIDTH = 2
);
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;

    // CPU fetch side
    logic                   i_rd;
    logic [ADDR_WIDTH-1:0]  i_addr;
    logic                   i_flush;
    logic                   o_ready;
    logic                   o_valid;
    logic [DATA_WIDTH-1:0]  o_data;
    logic                   o_busy;

    // backing memory side
    logic                   o_mem_rd;
    logic [ADDR_WIDTH-1:0]  o_mem_addr;
    logic                   i_mem_ack;
    logic [DATA_WIDTH-1:0]  i_mem_data;

    // cache-set datapath side
    logic [INDEX_WIDTH-1:0] o_set_index;
    logic [TAG_WIDTH-1:0]   o_set_tag;
    logic                   o_set_wr;
    logic                   o_set_cl;
    logic [DATA_WIDTH-1:0]  o_set_data;
    logic [DATA_WIDTH-1:0]  i_set_data;
    logic                   i_set_hit;

    // controller side
    modport slave (
        input  i_rd, i_addr, i_flush, i_mem_ack, i_mem_data, i_set_data, i_set_hit,
        output o_ready, o_valid, o_data, o_busy, o_mem_rd, o_mem_addr,
               o_set_index, o_set_tag, o_set_wr, o_set_cl, o_set_data
    );

    // CPU / memory / datapath environment side
    modport master (
        output i_rd, i_addr, i_flush, i_mem_ack, i_mem_data, i_set_data, i_set_hit,
        input  o_ready, o_valid, o_data, o_busy, o_mem_rd, o_mem_addr,
               o_set_index, o_set_tag, o_set_wr, o_set_cl, o_set_data
    );
endinterface

// File: rtl/icache_controller.sv
// Sequencing FSM for a direct-mapped read-only icache around one cache-set datapath.
// Latency: hit 1 cycle after acceptance, miss 2 + memory latency; invalidate sweep 2^INDEX_WIDTH cycles.
// Backpressure: o_ready low during sweeps, misses and flush requests; o_mem_rd held until i_mem_ack.
module icache_controller #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int INDEX_WIDTH  = 6,
    parameter int OFFSET_WIDTH = 2
) (
    input  logic               i_clock,
    input  logic               i_reset,
    icache_controller_if.slave bus
);
    localparam int TAG_WIDTH  = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int WORD_WIDTH = ADDR_WIDTH - OFFSET_WIDTH;
    localparam logic [INDEX_WIDTH-1:0] SWEEP_ONE  = 1;
    localparam logic [INDEX_WIDTH-1:0] SWEEP_LAST = '1;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOOKUP,
        ST_FILL,
        ST_FLUSH
    } state_t;

    state_t                 state;
    logic [INDEX_WIDTH-1:0] sweep_cnt;
    logic [WORD_WIDTH-1:0]  word_q;        // latched fetch address, byte offset dropped
    logic                   flush_pending; // flush seen mid-fill, honoured once the fill lands
    logic                   mem_rd_q;

    logic [WORD_WIDTH-1:0]  word_in;
    assign word_in = bus.i_addr[ADDR_WIDTH-1:OFFSET_WIDTH];

    // byte-offset bits never select anything in a word-wide line
    wire unused_offset = ^bus.i_addr[OFFSET_WIDTH-1:0];

    function automatic logic [INDEX_WIDTH-1:0] idx_of(input logic [WORD_WIDTH-1:0] w);
        return w[INDEX_WIDTH-1:0];
    endfunction

    function automatic logic [TAG_WIDTH-1:0] tag_of(input logic [WORD_WIDTH-1:0] w);
        return w[WORD_WIDTH-1 -: TAG_WIDTH];
    endfunction

    // state sequencing, sweep counter, address latch and the memory read request
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state         <= ST_INIT;
            sweep_cnt     <= '0;
            word_q        <= '0;
            flush_pending <= 1'b0;
            mem_rd_q      <= 1'b0;
        end else begin
            case (state)
                ST_INIT, ST_FLUSH: begin
                    sweep_cnt <= sweep_cnt + SWEEP_ONE;
                    if (sweep_cnt == SWEEP_LAST) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (bus.i_flush) begin
                        state         <= ST_FLUSH;
                        flush_pending <= 1'b0;
                    end else if (bus.i_rd) begin
                        word_q <= word_in;
                        state  <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (bus.i_set_hit) begin
                        if (bus.i_rd && !bus.i_flush) begin
                            word_q <= word_in;
                        end else if (bus.i_flush) begin
                            state         <= ST_FLUSH;
                            flush_pending <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        state    <= ST_FILL;
                        mem_rd_q <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (bus.i_mem_ack) begin
                        mem_rd_q      <= 1'b0;
                        flush_pending <= 1'b0;
                        if (flush_pending || bus.i_flush) begin
                            state <= ST_FLUSH;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (bus.i_flush) begin
                        flush_pending <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

    assign bus.o_mem_rd   = mem_rd_q;
    assign bus.o_mem_addr = {word_q, {OFFSET_WIDTH{1'b0}}};

    // CPU and datapath outputs decoded from state; everything is forced low while reset is held
    always_comb begin
        bus.o_ready     = 1'b0;
        bus.o_valid     = 1'b0;
        bus.o_data      = '0;
        bus.o_busy      = 1'b0;
        bus.o_set_index = '0;
        bus.o_set_tag   = '0;
        bus.o_set_wr    = 1'b0;
        bus.o_set_cl    = 1'b0;
        bus.o_set_data  = '0;
        if (i_reset) begin
            case (state)
                ST_INIT, ST_FLUSH: begin
                    bus.o_busy      = 1'b1;
                    bus.o_set_cl    = 1'b1;
                    bus.o_set_index = sweep_cnt;
                end
                ST_IDLE: begin
                    bus.o_ready     = !bus.i_flush;
                    bus.o_set_index = idx_of(word_in);
                    bus.o_set_tag   = tag_of(word_in);
                end
                ST_LOOKUP: begin
                    // the compare uses the latched tag while the index already points at the next fetch
                    bus.o_set_tag = tag_of(word_q);
                    if (bus.i_set_hit) begin
                        bus.o_set_index = idx_of(word_in);
                        bus.o_valid     = 1'b1;
                        bus.o_data      = bus.i_set_data;
                        bus.o_ready     = !bus.i_flush;
                    end else begin
                        bus.o_set_index = idx_of(word_q);
                    end
                end
                ST_FILL: begin
                    bus.o_set_index = idx_of(word_q);
                    bus.o_set_tag   = tag_of(word_q);
                    if (bus.i_mem_ack) begin
                        bus.o_set_wr   = 1'b1;
                        bus.o_set_data = bus.i_mem_data;
                        bus.o_valid    = 1'b1;
                        bus.o_data     = bus.i_mem_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_icache_controller.sv
// Directed bench for icache_controller with a set-datapath model, memory responder and fetch scoreboard.
// Latency: checks hit = 1 and miss = 2 + memory latency cycles after acceptance.
// Backpressure: waits on o_ready before each fetch; every wait is bounded.
module tb_icache_controller;
    localparam int LINES = 64;
    localparam int LIMIT = 300;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    icache_controller_if bus ();
    icache_controller dut (.i_clock(clk), .i_reset(rst_n), .bus(bus));

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] data;
        bit          hit;
    } exp_t;

    exp_t        exp_q[$];
    bit          mval[LINES];
    logic [23:0] mtag[LINES];

    int          checks = 0;
    int          failures = 0;
    int          mem_rd_cycles = 0;
    int          wr_count = 0;
    logic [5:0]  last_wr_idx = '0;
    logic [31:0] last_data = '0;
    logic [31:0] last_mem_addr = '0;
    logic        mem_rd_prev = 1'b0;
    bit          mem_auto = 1'b1;
    int          mem_lat = 3;
    int          stale_req = 0;
    int          stale_done = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // backing-memory contents: an arbitrary fixed word per address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_1004) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    // fetch-level model: is the line resident, and which word must come back
    task automatic model_push(input logic [31:0] a);
        exp_t e;
        int   idx;
        idx     = int'(a[7:2]);
        e.waddr = {a[31:2], 2'b00};
        e.hit   = mval[idx] && (mtag[idx] == a[31:8]);
        e.data  = mem_word(e.waddr);
        mval[idx] = 1'b1;
        mtag[idx] = a[31:8];
        exp_q.push_back(e);
    endtask

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) mval[i] = 1'b0;
    endtask

    // cache-set datapath: synchronous arrays, registered read index, combinational hit
    logic [23:0] st_tag[LINES];
    logic [31:0] st_dat[LINES];
    logic        st_val[LINES];
    logic [5:0]  rd_idx;

    initial begin
        // every line starts valid with a tag that real fetches use, so only the INIT sweep can clear it
        for (int i = 0; i < LINES; i++) begin
            st_val[i] = 1'b1;
            st_tag[i] = 24'h000010;
            st_dat[i] = 32'hBAD0_0000 + i;
        end
        rd_idx = '0;
    end

    always @(posedge clk) begin
        rd_idx <= bus.o_set_index;
        if (bus.o_set_cl) st_val[bus.o_set_index] <= 1'b0;
        if (bus.o_set_wr) begin
            st_val[bus.o_set_index] <= 1'b1;
            st_tag[bus.o_set_index] <= bus.o_set_tag;
            st_dat[bus.o_set_index] <= bus.o_set_data;
        end
    end

    assign bus.i_set_hit  = st_val[rd_idx] && (st_tag[rd_idx] == bus.o_set_tag);
    assign bus.i_set_data = st_dat[rd_idx];

    // memory responder: acks mem_lat cycles after o_mem_rd rises; can also inject one stray ack
    initial begin
        bus.i_mem_ack  = 1'b0;
        bus.i_mem_data = '0;
        forever begin
            sync();
            if (stale_req != stale_done) begin
                stale_done     = stale_req;
                bus.i_mem_ack  = 1'b1;
                bus.i_mem_data = 32'h5A5A_5A5A;
                sync();
                bus.i_mem_ack  = 1'b0;
                bus.i_mem_data = '0;
            end else if (mem_auto && bus.o_mem_rd) begin
                repeat (mem_lat) sync();
                bus.i_mem_ack  = 1'b1;
                bus.i_mem_data = mem_word(bus.o_mem_addr);
                sync();
                bus.i_mem_ack  = 1'b0;
                bus.i_mem_data = '0;
            end
        end
    end

    // compare process: every cycle, outputs against the fetch model and the standing rules
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            chk("reset_outputs_low",
                {bus.o_ready, bus.o_valid, bus.o_busy, bus.o_mem_rd, bus.o_set_wr, bus.o_set_cl,
                 |bus.o_data, |bus.o_mem_addr, |bus.o_set_index, |bus.o_set_tag, |bus.o_set_data}, 0);
        end else begin
            chk("wr_cl_exclusive", bus.o_set_wr && bus.o_set_cl, 0);
            chk("quiet_while_busy", bus.o_busy && (bus.o_valid || bus.o_set_wr), 0);
            if (bus.o_mem_rd && !mem_rd_prev) begin
                last_mem_addr = bus.o_mem_addr;
                if (exp_q.size() == 0) begin
                    chk("mem_rd_without_fetch", bus.o_mem_rd, 0);
                end else begin
                    chk("mem_addr", bus.o_mem_addr, exp_q[0].waddr);
                    chk("mem_rd_only_on_miss", exp_q[0].hit, 0);
                end
            end
            if (bus.o_mem_rd) mem_rd_cycles++;
            if (bus.o_valid) begin
                last_data = bus.o_data;
                if (exp_q.size() == 0) begin
                    chk("valid_without_fetch", bus.o_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("o_data", bus.o_data, e.data);
                    chk("fill_with_miss_valid", bus.o_set_wr, !e.hit);
                end
            end
            if (bus.o_set_wr) begin
                wr_count++;
                last_wr_idx = bus.o_set_index;
            end
        end
        mem_rd_prev = bus.o_mem_rd;
    end

    // one fetch: wait for o_ready, then measure cycles from acceptance to o_valid
    task automatic fetch(input logic [31:0] a, output int lat);
        int n;
        n = 0;
        bus.i_rd   = 1'b1;
        bus.i_addr = a;
        @(negedge clk);
        while (!bus.o_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_accept", bus.o_ready, 1);
        model_push(a);
        sync();
        bus.i_rd = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.o_valid && lat < LIMIT);
        chk("fetch_valid", bus.o_valid, 1);
        sync();
    endtask

    // invalidate sweep: busy and clear for exactly LINES cycles, indices ascending, then ready
    task automatic sweep_check();
        for (int i = 0; i < LINES; i++) begin
            @(negedge clk);
            chk("sweep_busy", bus.o_busy, 1);
            chk("sweep_cl", bus.o_set_cl, 1);
            chk("sweep_index", bus.o_set_index, i);
        end
        @(negedge clk);
        chk("sweep_done_busy", bus.o_busy, 0);
        chk("sweep_done_ready", bus.o_ready, 1);
        sync();
    endtask

    initial begin
        int lat;
        int base;
        logic [31:0] a;
        bus.i_rd    = 1'b0;
        bus.i_addr  = '0;
        bus.i_flush = 1'b0;
        model_clear();

        // reset, then the INIT sweep
        repeat (3) sync();
        rst_n = 1'b1;
        sweep_check();

        // cold miss then hit on the same word
        fetch(32'h0000_1004, lat);
        chk("cold_miss_latency", lat, 5);
        chk("cold_mem_addr", last_mem_addr, 32'h0000_1004);
        chk("cold_fill_index", last_wr_idx, 1);
        chk("cold_data", last_data, 32'hDEAD_BEEF);
        base = mem_rd_cycles;
        fetch(32'h0000_1006, lat);
        chk("hit_latency", lat, 1);
        chk("hit_no_mem_rd", mem_rd_cycles - base, 0);
        chk("hit_data", last_data, 32'hDEAD_BEEF);

        // warm the neighbours, then four back-to-back hits
        fetch(32'h0000_1000, lat);
        chk("warm_1000_latency", lat, 5);
        fetch(32'h0000_1008, lat);
        fetch(32'h0000_100C, lat);
        chk("warm_100c_latency", lat, 5);
        base = mem_rd_cycles;
        for (int k = 0; k < 4; k++) begin
            a = 32'h0000_1000 + 32'(4 * k);
            bus.i_rd   = 1'b1;
            bus.i_addr = a;
            @(negedge clk);
            chk("stream_ready", bus.o_ready, 1);
            chk("stream_valid", bus.o_valid, k > 0);
            model_push(a);
            sync();
        end
        bus.i_rd = 1'b0;
        @(negedge clk);
        chk("stream_valid_last", bus.o_valid, 1);
        sync();
        chk("stream_no_mem_rd", mem_rd_cycles - base, 0);

        // conflict on index 1: evict and re-fetch
        fetch(32'h0000_2004, lat);
        chk("conflict_miss_latency", lat, 5);
        chk("conflict_fill_index", last_wr_idx, 1);
        fetch(32'h0000_1004, lat);
        chk("evicted_miss_latency", lat, 5);
        chk("evicted_data", last_data, 32'hDEAD_BEEF);

        // flush pulsed mid-fill: fill completes, then a full sweep
        fork
            fetch(32'h0000_3008, lat);
            begin
                repeat (3) sync();
                bus.i_flush = 1'b1;
                sync();
                bus.i_flush = 1'b0;
            end
        join
        chk("flush_mid_fill_latency", lat, 5);
        model_clear();
        sweep_check();
        fetch(32'h0000_1004, lat);
        chk("after_flush_miss_latency", lat, 5);

        // flush in IDLE wins over a simultaneous fetch
        bus.i_flush = 1'b1;
        bus.i_rd    = 1'b1;
        bus.i_addr  = 32'h0000_1004;
        @(negedge clk);
        chk("idle_flush_not_ready", bus.o_ready, 0);
        sync();
        bus.i_flush = 1'b0;
        bus.i_rd    = 1'b0;
        model_clear();
        sweep_check();

        // reset dropped while a memory read is outstanding, stray ack during INIT
        mem_auto   = 1'b0;
        bus.i_rd   = 1'b1;
        bus.i_addr = 32'h0000_1008;
        @(negedge clk);
        chk("pre_reset_accept", bus.o_ready, 1);
        model_push(32'h0000_1008);
        sync();
        bus.i_rd = 1'b0;
        sync();
        @(negedge clk);
        chk("pre_reset_mem_rd", bus.o_mem_rd, 1);
        sync();
        rst_n = 1'b0;
        #1;
        chk("reset_drops_mem_rd", bus.o_mem_rd, 0);
        chk("reset_no_valid", bus.o_valid, 0);
        exp_q.delete();
        model_clear();
        repeat (3) sync();
        base = wr_count;
        rst_n = 1'b1;
        stale_req++;
        sweep_check();
        chk("stale_ack_no_write", wr_count - base, 0);
        mem_auto = 1'b1;
        fetch(32'h0000_1008, lat);
        chk("post_reset_miss_latency", lat, 5);

        repeat (3) sync();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
